// File: rtl/spi_pwm_config_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_pwm_config_pkg: register map, frame size and FSM encoding         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package spi_pwm_config_pkg;

    localparam int ADDR_EN_OUT_LO = 0;
    localparam int ADDR_EN_OUT_HI = 1;
    localparam int ADDR_EN_PWM_LO = 2;
    localparam int ADDR_EN_PWM_HI = 3;
    localparam int ADDR_DUTY      = 4;

    localparam int FRAME_BITS     = 16;
    localparam int CNT_W          = 5;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_RECV      = 2'd2,
        ST_COMMIT    = 2'd3
    } spi_state_t;

endpackage : spi_pwm_config_pkg
`default_nettype wire

// File: rtl/spi_input_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_input_sync: multi-flop synchronizer with rise/fall detection      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Chain resets low so a pin that is high at reset release shows up as a
    // rising edge, which the WAIT_IDLE state deliberately ignores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign o_fall = ~r_sync[SYNC_STAGES-1] & r_hist;

endmodule : spi_input_sync
`default_nettype wire

// File: rtl/spi_pwm_config.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_pwm_config: SPI mode-0 write-only slave for PWM config registers  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module spi_pwm_config
    import spi_pwm_config_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int MAX_ADDR    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle,
    output logic              wr_strobe,
    output logic              frame_err
);

    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_ncs_sync,  w_ncs_rise,  w_ncs_fall;
    logic w_copi_sync, w_copi_rise, w_copi_fall;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(sclk),
        .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .i_async(ncs),
        .o_sync(w_ncs_sync), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
    );
    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .i_async(copi),
        .o_sync(w_copi_sync), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
    );

    logic w_unused;
    assign w_unused = &{1'b0, w_sclk_sync, w_sclk_fall, w_copi_rise, w_copi_fall};

    spi_state_t             r_state, w_state_nxt;
    logic [FRAME_BITS-1:0]  r_shreg;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_W-1:0]      r_regs [MAX_ADDR+1];
    logic                   r_wr_strobe, r_frame_err;
    logic                   w_clear, w_shift, w_accept, w_reject, w_frame_ok;
    logic [ADDR_W-1:0]      w_addr;
    logic [DATA_W-1:0]      w_data;

    assign w_addr     = r_shreg[DATA_W +: ADDR_W];
    assign w_data     = r_shreg[DATA_W-1:0];
    assign w_frame_ok = (r_bit_cnt == CNT_W'(FRAME_BITS)) && r_shreg[FRAME_BITS-1]
                        && (w_addr <= ADDR_W'(MAX_ADDR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_WAIT_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_shift     = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            ST_WAIT_IDLE: begin
                w_clear = 1'b1;
                if (w_ncs_sync) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                w_clear = 1'b1;
                if (w_ncs_fall) w_state_nxt = ST_RECV;
            end
            ST_RECV: begin
                w_shift = w_sclk_rise & ~w_ncs_sync;
                if (w_ncs_rise) w_state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_accept    = w_frame_ok;
                w_reject    = ~w_frame_ok;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_WAIT_IDLE;
        endcase
    end

    // Bit count saturates one past a full frame so over-length frames stay rejected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            for (int i = 0; i <= MAX_ADDR; i++) r_regs[i] <= '0;
        end else begin
            r_wr_strobe <= w_accept;
            r_frame_err <= w_reject;
            if (w_clear) begin
                r_shreg   <= '0;
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_shreg <= {r_shreg[FRAME_BITS-2:0], w_copi_sync};
                if (r_bit_cnt != CNT_W'(FRAME_BITS + 1)) r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_accept) begin
                case (w_addr)
                    ADDR_W'(ADDR_EN_OUT_LO): r_regs[ADDR_EN_OUT_LO] <= w_data;
                    ADDR_W'(ADDR_EN_OUT_HI): r_regs[ADDR_EN_OUT_HI] <= w_data;
                    ADDR_W'(ADDR_EN_PWM_LO): r_regs[ADDR_EN_PWM_LO] <= w_data;
                    ADDR_W'(ADDR_EN_PWM_HI): r_regs[ADDR_EN_PWM_HI] <= w_data;
                    ADDR_W'(ADDR_DUTY):      r_regs[ADDR_DUTY]      <= w_data;
                    default: ;
                endcase
            end
        end
    end

    assign en_reg_out_7_0  = r_regs[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = r_regs[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = r_regs[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = r_regs[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = r_regs[ADDR_DUTY];
    assign wr_strobe       = r_wr_strobe;
    assign frame_err       = r_frame_err;

endmodule : spi_pwm_config
`default_nettype wire

// File: tb/tb_spi_pwm_config.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_pwm_config: directed vector bench for spi_pwm_config           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_spi_pwm_config;

    logic       clk = 1'b0;
    logic       rst_n, sclk, copi, ncs;
    logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
    logic       wr_strobe, frame_err;
    logic [39:0] regs_w;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;
    int n_err   = 0;

    always #5 clk = ~clk;

    spi_pwm_config #(
        .SYNC_STAGES(2), .ADDR_W(7), .DATA_W(8), .MAX_ADDR(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(out_lo), .en_reg_out_15_8(out_hi),
        .en_reg_pwm_7_0(pwm_lo), .en_reg_pwm_15_8(pwm_hi),
        .pwm_duty_cycle(duty), .wr_strobe(wr_strobe), .frame_err(frame_err)
    );

    assign regs_w = {duty, pwm_hi, pwm_lo, out_hi, out_lo};

    always @(negedge clk) begin
        if (wr_strobe) n_wr++;
        if (frame_err) n_err++;
    end

    typedef struct {
        logic [31:0] frame;
        int          nbits;
        logic [39:0] exp_regs;
        int          exp_wr;
        int          exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_begin();
        ncs = 1'b0;
        wait_clk(3);
    endtask

    task automatic spi_bits(input logic [31:0] value, input int nbits);
        logic [31:0] v;
        v = value;
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = v[i];
            wait_clk(3);
            sclk = 1'b1;
            wait_clk(3);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_end(input int gap);
        wait_clk(3);
        ncs = 1'b1;
        wait_clk(gap);
    endtask

    task automatic spi_frame(input logic [31:0] value, input int nbits, input int gap);
        spi_begin();
        spi_bits(value, nbits);
        spi_end(gap);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, err0;

        // {duty, pwm_hi, pwm_lo, out_hi, out_lo}
        vecs[0] = '{32'h0000_80FF, 16, 40'h00_00_00_00_FF, 1, 0};
        vecs[1] = '{32'h0000_8480, 16, 40'h80_00_00_00_FF, 1, 0};
        vecs[2] = '{32'h0000_8201, 16, 40'h80_00_01_00_FF, 1, 0};
        vecs[3] = '{32'h0000_0455, 16, 40'h80_00_01_00_FF, 0, 1};
        vecs[4] = '{32'h0000_8755, 16, 40'h80_00_01_00_FF, 0, 1};
        vecs[5] = '{32'h0000_40FF, 15, 40'h80_00_01_00_FF, 0, 1};
        vecs[6] = '{32'h0001_8155, 17, 40'h80_00_01_00_FF, 0, 1};
        vecs[7] = '{32'h0000_0000,  0, 40'h80_00_01_00_FF, 0, 1};
        vecs[8] = '{32'h0000_81AA, 16, 40'h80_00_01_AA_FF, 1, 0};

        rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        wait_clk(5);
        check("reset_regs", regs_w, 40'h0);
        check("reset_wr_strobe", {39'h0, wr_strobe}, 40'h0);
        check("reset_frame_err", {39'h0, frame_err}, 40'h0);
        rst_n = 1'b1;
        wait_clk(6);

        for (int i = 0; i < 9; i++) begin
            wr0  = n_wr;
            err0 = n_err;
            spi_frame(vecs[i].frame, vecs[i].nbits, 8);
            check($sformatf("vec%0d_regs", i), regs_w, vecs[i].exp_regs);
            check($sformatf("vec%0d_wr_pulses", i), 40'(n_wr - wr0), 40'(vecs[i].exp_wr));
            check($sformatf("vec%0d_err_pulses", i), 40'(n_err - err0), 40'(vecs[i].exp_err));
        end

        // Reset mid-frame, released while ncs is still low.
        wr0 = n_wr;
        spi_begin();
        spi_bits(32'h83, 8);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_async_clear", regs_w, 40'h0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);
        spi_bits(32'hF0, 8);
        spi_end(8);
        check("midreset_regs", regs_w, 40'h0);
        check("midreset_wr_pulses", 40'(n_wr - wr0), 40'h0);
        wr0 = n_wr;
        spi_frame(32'h83F0, 16, 8);
        check("after_reset_regs", regs_w, 40'h00_F0_00_00_00);
        check("after_reset_wr_pulses", 40'(n_wr - wr0), 40'h1);

        // Back-to-back writes, sclk = clk/6, 3-cycle ncs gaps.
        wr0  = n_wr;
        err0 = n_err;
        spi_frame(32'h8011, 16, 3);
        spi_frame(32'h8122, 16, 3);
        spi_frame(32'h8233, 16, 3);
        spi_frame(32'h8344, 16, 3);
        spi_frame(32'h8455, 16, 3);
        wait_clk(8);
        check("b2b_regs", regs_w, 40'h55_44_33_22_11);
        check("b2b_wr_pulses", 40'(n_wr - wr0), 40'h5);
        check("b2b_err_pulses", 40'(n_err - err0), 40'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spi_pwm_config
`default_nettype wire
